qsq_mult_pipe: RTL
==================

// Module: qsq_mult_pipe
// PURPOSE
//   Parametrised pipelined quarter-square multiplier: P = floor((A+B)^2/4) - floor((A-B)^2/4).
//   Square tables are generated at elaboration from WIDTH; there are no hand-entered constants.
//   Adds valid/ready flow control, back-pressure and a sideband tag to the fixed 8-bit square LUT.
//   Sits between operand sources and DSP-free datapaths that need one product per clock.
// PARAMETERS
//   WIDTH   8   operand width in bits (2..10); product is 2*WIDTH bits
//   TAG_W   4   sideband tag width, carried unchanged alongside each operand pair
// PORTS
//   CLK        in   1          clock, rising edge
//   RSTn       in   1          asynchronous active-low reset
//   in_valid   in   1          operand pair A/B/in_tag valid
//   in_ready   out  1          block accepts operands this cycle
//   A          in   WIDTH      multiplicand
//   B          in   WIDTH      multiplier
//   in_tag     in   TAG_W      sideband tag
//   out_valid  out  1          P/out_tag valid
//   out_ready  in   1          downstream accepts P this cycle
//   P          out  2*WIDTH    product
//   out_tag    out  TAG_W      tag of the pair that produced P
// BEHAVIOUR
//   - Reset (async, RSTn=0): all valid bits, P, out_tag and every pipeline register = 0; in_ready = 1 after reset.
//   - Three register stages, each with a valid bit; global enable en = !out_valid | out_ready.
//   - in_ready = en (combinational). Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   - S1: S = A+B (WIDTH+1 bits, no overflow); D = |A-B| (WIDTH bits); register tag.
//   - S2: Qs = SQ4[S], Qd = SQ4[D], SQ4[i] = floor(i*i/4); Qs, Qd are 2*WIDTH bits; table depth 2^(WIDTH+1).
//   - S3: P = Qs - Qd, unsigned 2*WIDTH bits; result is exact (S and D share parity), never negative.
//   - Latency 3 cycles from input transfer to out_valid when no stall; throughput 1 product/clock.
//   - en=0: all stages hold contents and valid bits; P and out_tag stable until taken; no data lost or duplicated.
//   - Bubbles (invalid stages) advance with en like data; valid bit of a stage loads 0 when its feeder is invalid.
//   - Simultaneous in/out transfer on a full pipe: allowed, pipe stays full.
//   - Reset mid-operation: all in-flight pairs discarded, out_valid drops immediately (async).
//   - P and out_tag are don't-care-free: they hold last value when out_valid=0 (benches compare only on transfer).
// CONFIGURATION
//   QSQ_SIGNED_EN defined: A, B, P are two's complement.
//     S1 takes magnitudes |A|, |B| (WIDTH bits; |-2^(WIDTH-1)| = 2^(WIDTH-1) fits) and registers sign = A[msb]^B[msb].
//     Sign is piped with valid; S3 outputs -(Qs-Qd) when sign=1. Latency, handshake unchanged.
//   QSQ_SIGNED_EN undefined: operands and P unsigned, no sign logic synthesised.
// TESTING
//   1. Reset, A=3,B=7,tag=5, one pulse, out_ready=1 -> out_valid 3 cycles later, P=21, out_tag=5, one cycle only.
//   2. Unsigned WIDTH=8: A=255,B=255 -> P=65025; A=0,B=200 -> P=0; A=229,B=1 -> P=229.
//   3. Stream 10 pairs back-to-back, out_ready=0 for cycles 4..7 -> in_ready=0 once full, P order/tags intact, no loss.
//   4. Full pipe, assert RSTn=0 for 1 cycle mid-stream -> out_valid=0 at once, no stale product after release.
//   5. QSQ_SIGNED_EN, WIDTH=8: -128*-128 -> 16384; -1*127 -> -127 (0xFF81); -128*127 -> -16256.
//   6. Exhaustive WIDTH=8 sweep, all 65536 pairs, random out_ready -> every P equals A*B, tags in order.

Source files
------------

// File: rtl/qsq_mult_pipe.sv
// ---------------------------------------------------------------------------
// qsq_mult_pipe
//   Pipelined quarter-square multiplier: P = floor((A+B)^2/4) - floor((A-B)^2/4).
//   The square table floor(i*i/4) is generated at elaboration from WIDTH.
//   Three register stages share one global enable, so a stalled output
//   freezes the whole pipe; one product per clock when not stalled.
//
//   Optional feature: define QSQ_SIGNED_EN to treat A, B and P as two's
//   complement (magnitudes are multiplied, the sign is piped alongside).
//
// Ports
//   CLK        in   1        clock, rising edge
//   RSTn       in   1        asynchronous active-low reset
//   in_valid   in   1        A/B/in_tag valid
//   in_ready   out  1        block accepts operands this cycle
//   A          in   WIDTH    multiplicand
//   B          in   WIDTH    multiplier
//   in_tag     in   TAG_W    sideband tag
//   out_valid  out  1        P/out_tag valid
//   out_ready  in   1        downstream accepts P this cycle
//   P          out  2*WIDTH  product
//   out_tag    out  TAG_W    tag of the pair that produced P
// ---------------------------------------------------------------------------
module qsq_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW    = 2 * WIDTH;
    localparam int SW    = WIDTH + 1;
    localparam int DEPTH = 1 << SW;

    // |x - y| for unsigned operands; the result always fits WIDTH bits.
    function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

`ifdef QSQ_SIGNED_EN
    // Magnitude of a two's complement value. The most negative value maps to
    // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] m,
                                                 input logic          neg);
        return neg ? (~m + 1'b1) : m;
    endfunction
`endif

    // Square table floor(i*i/4). The largest entry, at i = 2^(WIDTH+1)-1,
    // is 2^(2*WIDTH) - 2^WIDTH, so every entry fits in 2*WIDTH bits.
    logic [PW-1:0] sq4 [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sq4
        localparam longint SQV = (longint'(gi) * longint'(gi)) / 4;
        assign sq4[gi] = SQV[PW-1:0];
    end

    // Global enable: the pipe moves whenever the output slot is empty or
    // being taken this cycle.
    logic en;
    logic vld_p1, vld_p2, vld_p3;

    assign en        = !vld_p3 || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p3;

    // Operand preparation (combinational, feeds stage 1)
    logic [WIDTH-1:0] opa, opb;
    logic [SW-1:0]    s_c;
    logic [WIDTH-1:0] d_c;

`ifdef QSQ_SIGNED_EN
    logic sgn_c;
    assign opa   = magnitude(A);
    assign opb   = magnitude(B);
    assign sgn_c = A[WIDTH-1] ^ B[WIDTH-1];
`else
    assign opa = A;
    assign opb = B;
`endif

    assign s_c = {1'b0, opa} + {1'b0, opb};
    assign d_c = abs_diff(opa, opb);

    // ---- Stage 1: sum, absolute difference, tag ----
    logic [SW-1:0]    s_p1;
    logic [WIDTH-1:0] d_p1;
    logic [TAG_W-1:0] tag_p1;
`ifdef QSQ_SIGNED_EN
    logic             sgn_p1;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld_p1 <= 1'b0;
            s_p1   <= '0;
            d_p1   <= '0;
            tag_p1 <= '0;
`ifdef QSQ_SIGNED_EN
            sgn_p1 <= 1'b0;
`endif
        end else if (en) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                s_p1   <= s_c;
                d_p1   <= d_c;
                tag_p1 <= in_tag;
`ifdef QSQ_SIGNED_EN
                sgn_p1 <= sgn_c;
`endif
            end
        end
    end

    // ---- Stage 2: table lookups ----
    logic [PW-1:0]    qs_p2, qd_p2;
    logic [TAG_W-1:0] tag_p2;
`ifdef QSQ_SIGNED_EN
    logic             sgn_p2;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld_p2 <= 1'b0;
            qs_p2  <= '0;
            qd_p2  <= '0;
            tag_p2 <= '0;
`ifdef QSQ_SIGNED_EN
            sgn_p2 <= 1'b0;
`endif
        end else if (en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                qs_p2  <= sq4[s_p1];
                qd_p2  <= sq4[{1'b0, d_p1}];
                tag_p2 <= tag_p1;
`ifdef QSQ_SIGNED_EN
                sgn_p2 <= sgn_p1;
`endif
            end
        end
    end

    // ---- Stage 3: difference of quarter squares ----
    // S and D share parity, so the floors cancel and Qs - Qd is exact and
    // never negative. P only updates on a valid result, so it holds otherwise.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld_p3  <= 1'b0;
            P       <= '0;
            out_tag <= '0;
        end else if (en) begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
`ifdef QSQ_SIGNED_EN
                P <= apply_sign(qs_p2 - qd_p2, sgn_p2);
`else
                P <= qs_p2 - qd_p2;
`endif
                out_tag <= tag_p2;
            end
        end
    end

endmodule
